tag_free_list: RTL and testbench

TAG_FREE_LIST -- requirements
Module: tag_free_list

---
 rtl/tag_free_list_pkg.sv | 9 +
 rtl/tag_free_list_dec4.sv | 12 +
 rtl/tag_free_list.sv | 93 +++++++++
 tb/tb_tag_free_list.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/tag_free_list_pkg.sv
// Shared constants and types for the rename-stage tag free list.
package tag_free_list_pkg;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned TAG_W = 4;

    typedef logic [TAG_W-1:0] tag_t;

endpackage

// File: rtl/tag_free_list_dec4.sv
// 4-to-16 one-hot decoder used for the allocated tag's write-enable vector.
module tag_free_list_dec4 (
    input  logic [3:0]  sel_i,
    output logic [15:0] onehot_o
);

    always_comb begin
        onehot_o = 16'h0000;
        onehot_o[sel_i] = 1'b1;
    end

endmodule

// File: rtl/tag_free_list.sv
// Circular free list of rename tags: allocate from head, return to tail, sticky overflow flag.
module tag_free_list #(
    parameter int unsigned DEPTH = tag_free_list_pkg::DEPTH,
    parameter int unsigned TAG_W = tag_free_list_pkg::TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_req,
    output logic             alloc_gnt,
    output logic [TAG_W-1:0] alloc_tag,
    output logic [DEPTH-1:0] alloc_onehot,
    input  logic             free_valid,
    input  logic [TAG_W-1:0] free_tag,
    output logic [TAG_W:0]   count,
    output logic             empty,
    output logic             full,
    output logic             overflow_err
);

    import tag_free_list_pkg::*;

    tag_t             entry_q [DEPTH];
    tag_t             entry_d [DEPTH];
    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             free_acc;

    assign empty        = (count_q == '0);
    assign full         = (count_q == (TAG_W+1)'(DEPTH));
    assign alloc_gnt    = alloc_req & ~empty;
    // A free while full is dropped; there is no bypass from free to alloc.
    assign free_acc     = free_valid & ~full;
    assign alloc_tag    = entry_q[head_q];
    assign count        = count_q;
    assign overflow_err = overflow_q;

    tag_free_list_dec4 u_dec4 (
        .sel_i    (alloc_tag),
        .onehot_o (alloc_onehot)
    );

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q | (free_valid & full);
        if (alloc_gnt) begin
            head_d = head_q + 1'b1;
        end
        if (free_acc) begin
            tail_d = tail_q + 1'b1;
        end
        unique case ({free_acc, alloc_gnt})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= (TAG_W+1)'(DEPTH);
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        entry_d = entry_q;
        if (free_acc) begin
            entry_d[tail_q] = free_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= TAG_W'(i);
            end
        end else begin
            entry_q <= entry_d;
        end
    end

endmodule

// File: tb/tb_tag_free_list.sv
// Directed and pseudo-random bench for tag_free_list against a FIFO-of-tags model.
module tb_tag_free_list;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst;
    logic        alloc_req;
    logic        alloc_gnt;
    logic [3:0]  alloc_tag;
    logic [15:0] alloc_onehot;
    logic        free_valid;
    logic [3:0]  free_tag;
    logic [4:0]  count;
    logic        empty;
    logic        full;
    logic        overflow_err;

    int unsigned model[$];
    bit          m_ovf;
    bit          check_en;
    int          vectors;
    int          errors;

    int exp35[3]  = '{7, 3, 12};
    int exp36a[4] = '{10, 11, 13, 14};
    int exp36b[5] = '{15, 9, 9, 9, 9};
    int fill36[5] = '{10, 11, 13, 14, 15};

    tag_free_list dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_req    (alloc_req),
        .alloc_gnt    (alloc_gnt),
        .alloc_tag    (alloc_tag),
        .alloc_onehot (alloc_onehot),
        .free_valid   (free_valid),
        .free_tag     (free_tag),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every negedge: outputs must follow the queue of free tags held by the model.
    always @(negedge clk) begin
        int n;
        if (check_en) begin
            n = model.size();
            check("gnt", 32'(alloc_gnt), 32'(alloc_req && n > 0));
            check("count", 32'(count), 32'(n));
            check("empty", 32'(empty), 32'(n == 0));
            check("full", 32'(full), 32'(n == DEPTH));
            check("overflow", 32'(overflow_err), 32'(m_ovf));
            if (n > 0) begin
                check("tag", 32'(alloc_tag), model[0]);
                check("onehot", 32'(alloc_onehot), 32'(1) << model[0]);
            end else begin
                check("onehot_idle", 32'(alloc_onehot), 32'(1) << alloc_tag);
            end
        end
    end

    task automatic apply(input bit r, input bit req, input bit fv, input logic [3:0] ft);
        rst        = r;
        alloc_req  = req;
        free_valid = fv;
        free_tag   = ft;
        @(negedge clk);
        #1;
    endtask

    task automatic edge_step();
        int  n;
        bit  g;
        bit  f;
        @(posedge clk);
        n = model.size();
        if (rst) begin
            model.delete();
            for (int i = 0; i < DEPTH; i++) model.push_back(i);
            m_ovf = 1'b0;
        end else begin
            g = alloc_req && n > 0;
            f = free_valid && n < DEPTH;
            if (free_valid && n == DEPTH) m_ovf = 1'b1;
            if (g) void'(model.pop_front());
            if (f) model.push_back(int'(free_tag));
        end
        #1;
    endtask

    task automatic step(input bit r, input bit req, input bit fv, input logic [3:0] ft);
        apply(r, req, fv, ft);
        edge_step();
    endtask

    initial begin
        vectors    = 0;
        errors     = 0;
        check_en   = 1'b0;
        m_ovf      = 1'b0;
        rst        = 1'b1;
        alloc_req  = 1'b0;
        free_valid = 1'b0;
        free_tag   = 4'd0;
        edge_step();
        check_en = 1'b1;

        // Reset state
        apply(0, 1, 0, 0);
        check("rst_tag", 32'(alloc_tag), 0);
        check("rst_onehot", 32'(alloc_onehot), 32'h0001);
        check("rst_count", 32'(count), 16);
        check("rst_full", 32'(full), 1);
        check("rst_empty", 32'(empty), 0);
        check("rst_gnt", 32'(alloc_gnt), 1);
        check("rst_ovf", 32'(overflow_err), 0);

        // Drain all 16 tags in order
        for (int i = 0; i < DEPTH; i++) begin
            if (i != 0) apply(0, 1, 0, 0);
            check("drain_tag", 32'(alloc_tag), i);
            check("drain_onehot", 32'(alloc_onehot), 32'(1) << i);
            edge_step();
        end
        apply(0, 1, 0, 0);
        check("drained_empty", 32'(empty), 1);
        check("drained_gnt", 32'(alloc_gnt), 0);
        edge_step();

        // Empty with simultaneous free: no bypass
        apply(0, 1, 1, 4'd2);
        check("nobypass_gnt", 32'(alloc_gnt), 0);
        edge_step();
        apply(0, 1, 0, 0);
        check("bypass_next_gnt", 32'(alloc_gnt), 1);
        check("bypass_next_tag", 32'(alloc_tag), 2);
        edge_step();

        // Frees come back out in FIFO order
        for (int i = 0; i < 3; i++) step(0, 0, 1, 4'(exp35[i]));
        apply(0, 0, 0, 0);
        check("fifo_count", 32'(count), 3);
        edge_step();
        for (int i = 0; i < 3; i++) begin
            apply(0, 1, 0, 0);
            check("fifo_tag", 32'(alloc_tag), exp35[i]);
            edge_step();
        end

        // Steady alloc+free keeps count constant; tag 9 lands behind older entries
        for (int i = 0; i < 5; i++) step(0, 0, 1, 4'(fill36[i]));
        for (int i = 0; i < 4; i++) begin
            apply(0, 1, 1, 4'd9);
            check("steady_count", 32'(count), 5);
            check("steady_tag", 32'(alloc_tag), exp36a[i]);
            edge_step();
        end
        for (int i = 0; i < 5; i++) begin
            apply(0, 1, 0, 0);
            check("steady_drain_tag", 32'(alloc_tag), exp36b[i]);
            edge_step();
        end

        // Free while full: dropped, sticky overflow
        step(1, 0, 0, 0);
        apply(0, 0, 1, 4'd4);
        check("ovf_before", 32'(overflow_err), 0);
        edge_step();
        apply(0, 0, 0, 0);
        check("ovf_count", 32'(count), 16);
        check("ovf_set", 32'(overflow_err), 1);
        edge_step();
        step(0, 0, 0, 0);
        apply(0, 1, 1, 4'd5);
        check("ovf_sticky", 32'(overflow_err), 1);
        check("full_free_gnt", 32'(alloc_gnt), 1);
        edge_step();
        apply(0, 0, 0, 0);
        check("full_free_count", 32'(count), 15);
        edge_step();

        // Long mixed traffic so both pointers wrap several times
        step(1, 0, 0, 0);
        for (int i = 0; i < 160; i++) begin
            step(0, $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 55,
                 4'($urandom_range(0, 15)));
        end

        // Reset mid-stream with both requests active
        step(1, 1, 1, 4'd7);
        apply(0, 1, 0, 0);
        check("midrst_tag", 32'(alloc_tag), 0);
        check("midrst_onehot", 32'(alloc_onehot), 32'h0001);
        check("midrst_count", 32'(count), 16);
        check("midrst_full", 32'(full), 1);
        check("midrst_empty", 32'(empty), 0);
        check("midrst_gnt", 32'(alloc_gnt), 1);
        check("midrst_ovf", 32'(overflow_err), 0);
        edge_step();

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
